// File: rtl/switch_input_unit_if.sv
// Bundles the operator-input path of switch_input_unit: board-side raw inputs,
// the control-unit request, and the stall/grant/data results back to the CPU.
interface switch_input_unit_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] raw_switches;
    logic                  raw_enter;
    logic                  in_request;
    logic [DATA_WIDTH-1:0] switches_data;
    logic                  in_stall;
    logic                  in_ready;

    modport master (
        output raw_switches,
        output raw_enter,
        output in_request,
        input  switches_data,
        input  in_stall,
        input  in_ready
    );

    modport slave (
        input  raw_switches,
        input  raw_enter,
        input  in_request,
        output switches_data,
        output in_stall,
        output in_ready
    );
endinterface

// File: rtl/switch_input_unit.sv
// CPU IN-path front end: synchronises switches and the enter button, debounces
// the button, and stalls the PC until a fresh press grants one latched switch word.
module switch_input_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DATA_WIDTH      = 16
) (
    input  logic               clock,
    input  logic               reset,
    switch_input_unit_if.slave bus
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        GRANT        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] r_sw_s1;
    logic [DATA_WIDTH-1:0] r_sw_s2;
    logic                  r_en_s1;
    logic                  r_en_s2;
    logic                  r_enter_stable;
    logic                  r_enter_stable_d;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_switches_data;
    state_t                r_state;
    state_t                w_next_state;
    logic                  w_press_event;
    logic                  w_latch;

    // Two-flop synchronisers for the asynchronous switches and enter button
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sw_s1 <= {DATA_WIDTH{1'b0}};
            r_sw_s2 <= {DATA_WIDTH{1'b0}};
            r_en_s1 <= 1'b0;
            r_en_s2 <= 1'b0;
        end else begin
            r_sw_s1 <= bus.raw_switches;
            r_sw_s2 <= r_sw_s1;
            r_en_s1 <= bus.raw_enter;
            r_en_s2 <= r_en_s1;
        end
    end

    // Debouncer: any agreement with the stable level restarts the mismatch count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt            <= {CW{1'b0}};
            r_enter_stable   <= 1'b0;
            r_enter_stable_d <= 1'b0;
        end else begin
            r_enter_stable_d <= r_enter_stable;
            if (r_en_s2 == r_enter_stable) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_cnt == CNT_LAST) begin
                r_enter_stable <= r_en_s2;
                r_cnt          <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign w_press_event = r_enter_stable & ~r_enter_stable_d;

    // FSM state register and switch-word latch taken on the grant edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_switches_data <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_switches_data <= r_sw_s2;
            end
        end
    end

    // Next-state logic; a dropped request beats a coincident press
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_request) begin
                    w_next_state = WAIT_PRESS;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT_PRESS: begin
                if (!bus.in_request) begin
                    w_next_state = IDLE;
                end else if (w_press_event) begin
                    w_next_state = GRANT;
                    w_latch      = 1'b1;
                end else begin
                    w_next_state = WAIT_PRESS;
                end
            end
            GRANT: begin
                if (r_enter_stable) begin
                    w_next_state = WAIT_RELEASE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (!r_enter_stable) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT_RELEASE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Stall is combinational so the PC holds in the very cycle the request appears
    assign bus.in_ready      = (r_state == GRANT);
    assign bus.in_stall      = bus.in_request & (r_state != GRANT) & ~reset;
    assign bus.switches_data = r_switches_data;
endmodule

// File: tb/tb_switch_input_unit.sv
// Directed plus randomized bench for switch_input_unit, checked every cycle
// against a behavioural model of the debounce/grant rules.
module tb_switch_input_unit;
    localparam int D  = 4;
    localparam int DW = 16;
    localparam int P_IDLE = 0, P_WAIT = 1, P_GRANT = 2, P_REL = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req   = 1'b0;
    logic          enter = 1'b0;
    logic [DW-1:0] sw    = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;
    int grants   = 0;
    int took;

    // Model state: values as seen after the most recent clock edge
    logic          m_s1 = 1'b0, m_s2 = 1'b0, m_stable = 1'b0, m_stable_d = 1'b0;
    logic [DW-1:0] m_sw1 = 16'h0000, m_sw2 = 16'h0000, m_data = 16'h0000;
    int            m_run = 0;
    int            m_phase = P_IDLE;

    switch_input_unit_if #(.DATA_WIDTH(DW)) bus ();

    assign bus.raw_switches = sw;
    assign bus.raw_enter    = enter;
    assign bus.in_request   = req;

    switch_input_unit #(.DEBOUNCE_CYCLES(D), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: predict from pre-edge inputs, clock, then compare all outputs
    task automatic step();
        logic          n_s1, n_s2, n_stable, press;
        logic [DW-1:0] n_sw1, n_sw2, n_data;
        int            n_run, n_phase;
        if (reset) begin
            n_s1 = 1'b0; n_s2 = 1'b0; n_stable = 1'b0;
            n_sw1 = '0; n_sw2 = '0; n_data = '0;
            n_run = 0; n_phase = P_IDLE;
        end else begin
            n_s1 = enter; n_s2 = m_s1; n_sw1 = sw; n_sw2 = m_sw1;
            n_stable = m_stable; n_data = m_data; n_run = 0;
            // stable level flips after D consecutive disagreeing samples
            if (m_s2 != m_stable) begin
                n_run = m_run + 1;
                if (n_run == D) begin
                    n_stable = m_s2;
                    n_run    = 0;
                end
            end
            press   = m_stable && !m_stable_d;
            n_phase = m_phase;
            case (m_phase)
                P_IDLE:  if (req) n_phase = P_WAIT;
                P_WAIT:  if (!req) n_phase = P_IDLE;
                         else if (press) begin n_phase = P_GRANT; n_data = m_sw2; end
                P_GRANT: n_phase = m_stable ? P_REL : P_IDLE;
                P_REL:   if (!m_stable) n_phase = P_IDLE;
                default: n_phase = P_IDLE;
            endcase
        end
        m_stable_d = reset ? 1'b0 : m_stable;
        @(posedge clock);
        #1;
        m_s1 = n_s1; m_s2 = n_s2; m_sw1 = n_sw1; m_sw2 = n_sw2;
        m_stable = n_stable; m_run = n_run; m_phase = n_phase; m_data = n_data;
        chk("in_ready", 32'(bus.in_ready), 32'(m_phase == P_GRANT));
        chk("in_stall", 32'(bus.in_stall), 32'(req && (m_phase != P_GRANT) && !reset));
        chk("switches_data", 32'(bus.switches_data), 32'(m_data));
        if (bus.in_ready === 1'b1) grants++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_grant(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (bus.in_ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int hold;
        // Reset
        reset = 1'b1;
        run(2);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_stall", 32'(bus.in_stall), 32'd0);
        chk("rst_data", 32'(bus.switches_data), 32'd0);
        reset = 1'b0;

        // Basic IN: press sampled at edge 1, grant seen after edge 7
        sw = 16'hA5C3; req = 1'b1; enter = 1'b1;
        wait_grant(12, took);
        chk("basic_latency", 32'(took), 32'd7);
        chk("basic_data", 32'(bus.switches_data), 32'h0000A5C3);
        run(2);
        chk("basic_rel_stall", 32'(bus.in_stall), 32'd1);
        req = 1'b0; enter = 1'b0;
        run(10);

        // Bounce rejection
        grants = 0; req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enter = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        enter = 1'b0;
        run(8);
        chk("bounce_grants", 32'(grants), 32'd0);
        chk("bounce_stall", 32'(bus.in_stall), 32'd1);
        req = 1'b0;
        run(2);

        // Held button before request gives no grant
        enter = 1'b1;
        run(10);
        grants = 0; req = 1'b1;
        run(6);
        chk("held_grants", 32'(grants), 32'd0);
        enter = 1'b0;
        run(8);
        sw = 16'h1234; enter = 1'b1;
        wait_grant(12, took);
        chk("held_repress_grant", 32'(took), 32'd7);
        chk("held_data", 32'(bus.switches_data), 32'h00001234);
        enter = 1'b0; req = 1'b0;
        run(10);

        // Abort in WAIT_PRESS
        grants = 0; req = 1'b1;
        run(3);
        req = 1'b0; sw = 16'hFFFF; enter = 1'b1;
        run(10);
        chk("abort_grants", 32'(grants), 32'd0);
        chk("abort_data", 32'(bus.switches_data), 32'h00001234);
        enter = 1'b0;
        run(10);

        // Back-to-back IN
        sw = 16'hA5C3; req = 1'b1; enter = 1'b1;
        wait_grant(12, took);
        chk("b2b_first", 32'(bus.switches_data), 32'h0000A5C3);
        sw = 16'h0001;
        run(5);
        chk("b2b_stall", 32'(bus.in_stall), 32'd1);
        enter = 1'b0;
        run(8);
        enter = 1'b1;
        wait_grant(12, took);
        chk("b2b_second_seen", 32'(took), 32'd7);
        chk("b2b_second", 32'(bus.switches_data), 32'h00000001);
        enter = 1'b0; req = 1'b0;
        run(10);

        // Reset mid-operation with debounce counter at 2
        req = 1'b1; enter = 1'b1;
        run(4);
        reset = 1'b1;
        step();
        chk("midrst_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_stall", 32'(bus.in_stall), 32'd0);
        chk("midrst_data", 32'(bus.switches_data), 32'd0);
        reset = 1'b0;
        wait_grant(12, took);
        chk("midrst_full_debounce", 32'(took), 32'd7);
        enter = 1'b0; req = 1'b0;
        run(10);

        // Randomized operation against the model
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            sw = DW'($urandom);
            if ($urandom_range(0, 29) == 0) req = ~req;
            if (hold == 0) begin
                enter = ~enter;
                hold  = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_input_unit.md
Name: switch_input_unit

Overview:
Upstream input stage for the CPU's IN path. It synchronises the 16 board switches and an "enter" push-button, and debounces the button. It also holds the CPU while an IN instruction waits for the operator: when the control unit requests input, the block stalls the PC until a debounced button press. It then delivers a latched 16-bit switch word to the In Signal MUX for exactly one grant cycle.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised button must differ from its stable value before the stable value toggles (>=2; board build uses 500000)
DATA_WIDTH, 16, width of switch word

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  synchronous, active-high reset
raw_switches  input  DATA_WIDTH  asynchronous board switches
raw_enter  input  1  asynchronous push-button, 1 = pressed
in_request  input  1  from control unit (cu_inSignal); high while an IN instruction is current
switches_data  output  DATA_WIDTH  latched switch word to In Signal MUX
in_stall  output  1  to PC hold logic; 1 = do not advance PC
in_ready  output  1  one-cycle grant; switches_data is valid for the IN instruction in this cycle

Behaviour:
- Synchronisers:
  - Two-flop chains on raw_switches (sw_s1→sw_s2) and raw_enter (en_s1→en_s2).
  - No logic between the flops of a chain.
- Debouncer state: enter_stable plus a counter of width clog2(DEBOUNCE_CYCLES).
  - en_s2 == enter_stable: counter <= 0.
  - Otherwise, counter increments.
  - When the counter is DEBOUNCE_CYCLES-1 and a mismatch persists: enter_stable <= en_s2 and counter <= 0.
  - A raw level held steady from edge 1 (first sample) toggles enter_stable at edge DEBOUNCE_CYCLES+2.
  - Any bounce restarts the count.
- press_event = enter_stable & ~enter_stable_d, where enter_stable_d is enter_stable delayed one cycle. It is a one-cycle pulse in the cycle after the toggle edge.
- FSM states: IDLE, WAIT_PRESS, GRANT, WAIT_RELEASE.
  - IDLE: in_request=1 → WAIT_PRESS.
  - WAIT_PRESS:
    - in_request=0 → IDLE (abort; switches_data unchanged).
    - Otherwise, press_event=1 → GRANT, with switches_data <= sw_s2.
  - GRANT: lasts exactly one cycle. Next state is WAIT_RELEASE if enter_stable=1, else IDLE.
  - WAIT_RELEASE: enter_stable=0 → IDLE.
  - A request in WAIT_RELEASE stays stalled until release. It then passes through IDLE and WAIT_PRESS and needs a fresh press.
- Outputs:
  - in_ready = (state==GRANT).
  - in_stall = in_request & (state!=GRANT) & ~reset. It is combinational so the stall takes effect in the same cycle the request appears.
- Press while idle:
  - Presses while in_request=0 are ignored.
  - A button already held when a request arrives does not grant; only a new 0→1 enter_stable transition does.
- Simultaneous events: in_request falling in the same cycle as press_event in WAIT_PRESS → abort wins; state goes to IDLE and there is no latch.
- Latency: raw_enter first sampled at edge 1 → GRANT entered at edge DEBOUNCE_CYCLES+3 → in_ready high for the following cycle.
- Reset:
  - Synchronous; applies mid-operation from any state.
  - Sync flops, counter, enter_stable and enter_stable_d are cleared to 0.
  - state=IDLE, switches_data=0, in_ready=0, in_stall=0.
- Switches are not debounced; they are only synchronised and sampled at the grant edge.

Test Plan:
- Basic IN with DEBOUNCE_CYCLES=4:
  - Stimulus: raw_switches=16'hA5C3, in_request=1 from cycle 0, raw_enter high from edge 1.
  - Response: in_stall=1 through edge 7, then in_ready=1 and in_stall=0 for one cycle with switches_data=16'hA5C3.
  - Then state WAIT_RELEASE; lowering in_request returns to IDLE once released.
- Bounce rejection: raw_enter toggles 1,0,1,0 with 2-cycle pulses, then stays low → enter_stable stays 0, in_ready never asserts, in_stall held at 1.
- Held button: raw_enter held high and debounced before in_request rises → no grant. Release, then press again → grant with the switch value sampled at the grant edge.
- Abort: in_request drops while in WAIT_PRESS, then press → no in_ready, switches_data keeps its old value, state IDLE.
- Back-to-back IN:
  - Stimulus: in_request stays 1 after the grant while the button is still held; switches change to 16'h0001.
  - Response: stall continues through WAIT_RELEASE. After release and a new press, a second grant delivers 16'h0001.
- Reset mid-operation: assert reset for 1 cycle in WAIT_PRESS with counter=2 → next cycle all outputs 0, state IDLE, counter 0, and a fresh full debounce is needed.
